cam_ctrl: RTL

- Sequencing controller and arbiter that shares one cam instance between NUM_REQ requesters.
- Accepts READ, LOOKUP, INSERT and DELETE commands and issues the cam read/write/search enables.
- Tracks slot occupancy and performs insert-if-absent: a search, followed by a write to the lowest free slot on a miss.
- Sits between client logic and the cam; it is the only driver of the cam enables.

---
 rtl/cam_pkg.sv | 32 +++
 rtl/cam_rr_arbiter.sv | 46 ++++
 rtl/cam_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types for the cam sequencing controller: op codes, FSM states and
// the response flag bundle.
package cam_pkg;

    localparam int OP_WIDTH = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_READ   = 2'b00,
        OP_LOOKUP = 2'b01,
        OP_INSERT = 2'b10,
        OP_DELETE = 2'b11
    } cam_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } cam_ctrl_state_e;

    typedef struct packed {
        logic valid;
        logic hit;
        logic full;
    } cam_resp_t;

    function automatic logic is_search(cam_op_e op);
        return (op == OP_LOOKUP) || (op == OP_INSERT);
    endfunction

endpackage

// File: rtl/cam_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner whenever a grant is issued.
module cam_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               grant_en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     grant_idx_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] cand;
    logic           any_grant;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant   = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ((int'(ptr_q) + k) >= NUM_REQ) ? IDW'(int'(ptr_q) + k - NUM_REQ)
                                                  : IDW'(int'(ptr_q) + k);
            if (grant_en_i && !any_grant && req_i[cand]) begin
                any_grant     = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

    assign ptr_d = (grant_idx_o == IDW'(NUM_REQ - 1)) ? '0 : grant_idx_o + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (any_grant) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// Shares one cam between NUM_REQ requesters: READ/LOOKUP/INSERT/DELETE with
// occupancy tracking and insert-if-absent. Optional hit/miss counters: CAM_CTRL_STATS_EN.
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int               WIDTH           = 32,
    parameter int               ADDR_WIDTH      = 5,
    parameter int               HEIGHT          = 32,
    parameter int               NUM_REQ         = 2,
    parameter logic [WIDTH-1:0] INVALID_PATTERN = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef CAM_CTRL_STATS_EN
    input  logic                          stat_clear_i,
    output logic [31:0]                   stat_hit_o,
    output logic [31:0]                   stat_miss_o,
`endif
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_index_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_data_i,
    output logic                          resp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id_o,
    output logic                          resp_hit_o,
    output logic [ADDR_WIDTH-1:0]         resp_index_o,
    output logic [WIDTH-1:0]              resp_data_o,
    output logic                          resp_full_o,
    output logic                          full_o,
    output logic                          cam_read_enable_o,
    output logic [ADDR_WIDTH-1:0]         cam_read_index_o,
    output logic                          cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0]         cam_write_index_o,
    output logic [WIDTH-1:0]              cam_write_data_o,
    output logic                          cam_search_enable_o,
    output logic [WIDTH-1:0]              cam_search_data_o,
    input  logic                          cam_read_valid_i,
    input  logic [WIDTH-1:0]              cam_read_value_i,
    input  logic                          cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0]         cam_search_index_i
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    cam_ctrl_state_e       state_q;
    cam_op_e               op_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [WIDTH-1:0]      key_q;
    logic [IDW-1:0]        id_q;
    logic [HEIGHT-1:0]     occ_q;
    cam_resp_t             resp_q;
    logic [IDW-1:0]        resp_id_q;
    logic [ADDR_WIDTH-1:0] resp_index_q;
    logic [WIDTH-1:0]      resp_data_q;
    logic                  rd_en_q, wr_en_q, sr_en_q;
    logic [ADDR_WIDTH-1:0] rd_idx_q, wr_idx_q;
    logic [WIDTH-1:0]      wr_data_q, sr_data_q;

    logic [OP_WIDTH-1:0]   op_arr   [NUM_REQ];
    logic [ADDR_WIDTH-1:0] idx_arr  [NUM_REQ];
    logic [WIDTH-1:0]      data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        grant_idx;
    cam_op_e               sel_op;
    logic [ADDR_WIDTH-1:0] sel_index;
    logic [WIDTH-1:0]      sel_key;
    logic                  sel_in_range, idx_in_range, search_hit, full;
    logic [DEPTH-1:0]      occ_ext;
    logic [ADDR_WIDTH-1:0] free_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_arr[gi]   = req_op_i[gi*OP_WIDTH +: OP_WIDTH];
        assign idx_arr[gi]  = req_index_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[gi] = req_data_i[gi*WIDTH +: WIDTH];
    end

    cam_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_i),
        .req_i       (req_valid_i),
        .grant_en_i  (state_q == ST_IDLE),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign sel_op       = cam_op_e'(op_arr[grant_idx]);
    assign sel_index    = idx_arr[grant_idx];
    assign sel_key      = data_arr[grant_idx];
    assign sel_in_range = {1'b0, sel_index} < (ADDR_WIDTH+1)'(HEIGHT);
    assign idx_in_range = {1'b0, index_q} < (ADDR_WIDTH+1)'(HEIGHT);
    // Zero-extended occupancy so any cam index, even past HEIGHT, reads as free.
    assign occ_ext      = DEPTH'(occ_q);
    assign search_hit   = cam_search_valid_i && occ_ext[cam_search_index_i];
    assign full         = &occ_q;

    always_comb begin
        free_idx = '0;
        for (int i = HEIGHT - 1; i >= 0; i--) begin
            if (!occ_q[i]) free_idx = ADDR_WIDTH'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;  op_q <= OP_READ;  index_q <= '0;  key_q <= '0;
            id_q <= '0;  occ_q <= '0;  resp_q <= '0;  resp_id_q <= '0;
            resp_index_q <= '0;  resp_data_q <= '0;
            rd_en_q <= 1'b0;  rd_idx_q <= '0;  sr_en_q <= 1'b0;  sr_data_q <= '0;
            wr_en_q <= 1'b0;  wr_idx_q <= '0;  wr_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (|grant) begin
                    op_q <= sel_op;  index_q <= sel_index;  key_q <= sel_key;
                    id_q <= grant_idx;  state_q <= ST_ISSUE;
                    if (is_search(sel_op)) begin
                        sr_en_q <= 1'b1;  sr_data_q <= sel_key;
                    end else if (sel_in_range && sel_op == OP_READ) begin
                        rd_en_q <= 1'b1;  rd_idx_q <= sel_index;
                    end else if (sel_in_range) begin
                        wr_en_q <= 1'b1;  wr_idx_q <= sel_index;  wr_data_q <= INVALID_PATTERN;
                    end
                end
                ST_ISSUE: begin
                    rd_en_q <= 1'b0;  rd_idx_q <= '0;  sr_en_q <= 1'b0;  sr_data_q <= '0;
                    wr_en_q <= 1'b0;  wr_idx_q <= '0;  wr_data_q <= '0;
                    if (op_q == OP_DELETE) begin
                        if (idx_in_range) occ_q <= occ_q & ~(HEIGHT'(1) << index_q);
                        resp_q <= '{valid: 1'b1, hit: occ_ext[index_q], full: 1'b0};
                        resp_id_q <= id_q;  resp_index_q <= index_q;  state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    resp_id_q <= id_q;
                    if (op_q == OP_READ) begin
                        resp_q       <= '{valid: 1'b1, hit: occ_ext[index_q], full: 1'b0};
                        resp_index_q <= index_q;
                        resp_data_q  <= (idx_in_range && cam_read_valid_i) ? cam_read_value_i : '0;
                        state_q      <= ST_RESP;
                    end else if (search_hit || op_q != OP_INSERT || full) begin
                        resp_q       <= '{valid: 1'b1, hit: search_hit,
                                          full: !search_hit && op_q == OP_INSERT};
                        resp_index_q <= search_hit ? cam_search_index_i : '0;
                        state_q      <= ST_RESP;
                    end else begin
                        wr_en_q <= 1'b1;  wr_idx_q <= free_idx;  wr_data_q <= key_q;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    occ_q        <= occ_q | (HEIGHT'(1) << wr_idx_q);
                    resp_q       <= '{valid: 1'b1, hit: 1'b0, full: 1'b0};
                    resp_index_q <= wr_idx_q;
                    wr_en_q <= 1'b0;  wr_idx_q <= '0;  wr_data_q <= '0;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    resp_q <= '0;  resp_id_q <= '0;  resp_index_q <= '0;  resp_data_q <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CAM_CTRL_STATS_EN
    logic [31:0] stat_hit_q, stat_miss_q;
    logic        count_ev;

    assign count_ev = (state_q == ST_WAIT) && is_search(op_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else if (stat_clear_i) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else if (count_ev) begin
            if (search_hit && !(&stat_hit_q))   stat_hit_q  <= stat_hit_q + 1'b1;
            if (!search_hit && !(&stat_miss_q)) stat_miss_q <= stat_miss_q + 1'b1;
        end
    end

    assign stat_hit_o  = stat_hit_q;
    assign stat_miss_o = stat_miss_q;
`endif

    assign req_ready_o         = grant;
    assign resp_valid_o        = resp_q.valid;
    assign resp_hit_o          = resp_q.hit;
    assign resp_full_o         = resp_q.full;
    assign resp_id_o           = resp_id_q;
    assign resp_index_o        = resp_index_q;
    assign resp_data_o         = resp_data_q;
    assign full_o              = full;
    assign cam_read_enable_o   = rd_en_q;
    assign cam_read_index_o    = rd_idx_q;
    assign cam_write_enable_o  = wr_en_q;
    assign cam_write_index_o   = wr_idx_q;
    assign cam_write_data_o    = wr_data_q;
    assign cam_search_enable_o = sr_en_q;
    assign cam_search_data_o   = sr_data_q;

endmodule
